// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled start/data(LSB first)/stop deserialiser with done strobe.
// Latency: 2-cycle synchroniser plus bit timing; o_rx_done registered one cycle after final stop tick.
// Backpressure: none; o_data is held only until the next completed frame overwrites it.
module uart_rx #(
    parameter int DATA_BITS    = 8,
    parameter int OVERSAMPLING = 16,
    parameter int STOP_TICKS   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_error
);

    localparam int SMAX = (OVERSAMPLING > STOP_TICKS) ? OVERSAMPLING : STOP_TICKS;
    localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;
    localparam int NW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLING / 2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLING - 1);
    localparam logic [SW-1:0] S_STOP = SW'(STOP_TICKS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_nxt;
    logic                 rx_meta, rx_s;
    logic [SW-1:0]        s, s_nxt;
    logic [NW-1:0]        n, n_nxt;
    logic [DATA_BITS-1:0] shift, shift_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 done_nxt;
    logic                 ferr_nxt;

    // Idle-high line: synchroniser resets to 1 so reset never looks like a start edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!rx_s) state_nxt = START;
            START:   if (i_tick && s == S_HALF) state_nxt = rx_s ? IDLE : DATA;
            DATA:    if (i_tick && s == S_BIT && n == N_LAST) state_nxt = STOP;
            STOP:    if (i_tick && s == S_STOP) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_nxt     = s;
        n_nxt     = n;
        shift_nxt = shift;
        data_nxt  = o_data;
        ferr_nxt  = o_frame_error;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) s_nxt = '0;
            end
            START: begin
                if (i_tick) begin
                    if (s == S_HALF) begin
                        if (!rx_s) begin
                            s_nxt = '0;
                            n_nxt = '0;
                        end
                    end else begin
                        s_nxt = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (s == S_BIT) begin
                        s_nxt                    = '0;
                        shift_nxt                = shift >> 1;
                        shift_nxt[DATA_BITS-1]   = rx_s;
                        if (n != N_LAST) n_nxt   = n + 1'b1;
                    end else begin
                        s_nxt = s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (s == S_STOP) begin
                        data_nxt = shift;
                        ferr_nxt = ~rx_s;
                        done_nxt = 1'b1;
                    end else begin
                        s_nxt = s + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s             <= '0;
            n             <= '0;
            shift         <= '0;
            o_data        <= '0;
            o_rx_done     <= 1'b0;
            o_frame_error <= 1'b0;
        end else begin
            s             <= s_nxt;
            n             <= n_nxt;
            shift         <= shift_nxt;
            o_data        <= data_nxt;
            o_rx_done     <= done_nxt;
            o_frame_error <= ferr_nxt;
        end
    end

endmodule
